// File: rtl/thcattus_uart_rx.sv
// 8N1 UART receiver: oversamples the line at the system clock and packs
// DATA_WIDTH bytes (LSB first, byte 0 in [7:0]) into one AXI-Stream beat.
module thcattus_uart_rx #(
    parameter int DATA_WIDTH = 4,
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                      axis_aclk,
    input  logic                      axis_areset,
    input  logic                      uart_rx,
    output logic                      axis_tvalid,
    input  logic                      axis_tready,
    output logic [DATA_WIDTH*8-1:0]   axis_tdata,
    output logic                      rx_frame_error,
    output logic                      rx_overrun
);
    localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int BW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BCW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                    r_state;
    logic [BW-1:0]             r_baud_cnt;
    logic [2:0]                r_bit_cnt;
    logic [BCW-1:0]            r_byte_cnt;
    logic [7:0]                r_shift;
    logic [DATA_WIDTH*8-1:0]   r_word;
    logic                      r_rx_m;
    logic                      r_rx_s;

    logic                      w_baud_done;
    logic                      w_half_done;
    logic                      w_last_lane;
    logic [DATA_WIDTH*8-1:0]   w_full;

    assign w_baud_done = (r_baud_cnt == BW'(CPB - 1));
    assign w_half_done = (r_baud_cnt == BW'(HALF - 1));
    assign w_last_lane = (r_byte_cnt == BCW'(DATA_WIDTH - 1));

    // Completed word: lower lanes from r_word, top lane is the byte just received.
    always_comb begin
        w_full = r_word;
        w_full[(DATA_WIDTH-1)*8 +: 8] = r_shift;
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= uart_rx;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_state        <= S_IDLE;
            r_baud_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_byte_cnt     <= '0;
            r_shift        <= '0;
            r_word         <= '0;
            axis_tvalid    <= 1'b0;
            axis_tdata     <= '0;
            rx_frame_error <= 1'b0;
            rx_overrun     <= 1'b0;
        end else begin
            rx_frame_error <= 1'b0;
            rx_overrun     <= 1'b0;
            if (axis_tvalid && axis_tready)
                axis_tvalid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= S_START;
                        r_baud_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_half_done) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7)
                            r_state <= S_STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at mid stop bit so a start bit with no idle gap is caught.
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                        if (!r_rx_s) begin
                            rx_frame_error <= 1'b1;
                            r_byte_cnt     <= '0;
                        end else if (w_last_lane) begin
                            r_byte_cnt <= '0;
                            if (!axis_tvalid || axis_tready) begin
                                axis_tdata  <= w_full;
                                axis_tvalid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            r_word[r_byte_cnt*8 +: 8] <= r_shift;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_thcattus_uart_rx.sv
// Directed bench for thcattus_uart_rx at 10 clocks per bit, 4 bytes per beat.
module tb_thcattus_uart_rx;
    localparam int DW  = 4;
    localparam int CPB = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            line;
    logic            tready;
    logic            tvalid;
    logic [DW*8-1:0] tdata;
    logic            ferr;
    logic            ovr;

    int errors = 0;
    int checks = 0;

    logic [31:0] beats [64];
    int beat_total = 0;
    int ferr_total = 0;
    int ovr_total  = 0;

    thcattus_uart_rx #(.DATA_WIDTH(DW), .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
        .axis_aclk     (clk),
        .axis_areset   (rst),
        .uart_rx       (line),
        .axis_tvalid   (tvalid),
        .axis_tready   (tready),
        .axis_tdata    (tdata),
        .rx_frame_error(ferr),
        .rx_overrun    (ovr)
    );

    always #5 clk = ~clk;

    // Counts are cycles-high, so a pulse longer than one cycle shows as an extra count.
    always @(negedge clk) begin
        if (tvalid && tready && beat_total < 64) begin
            beats[beat_total] = tdata;
            beat_total++;
        end
        if (ferr) ferr_total++;
        if (ovr)  ovr_total++;
    end

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        line = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1; line = 1'b1; tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", tvalid); end
        checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got=%h want=00000000", tdata); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b want=0", ferr); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b want=0", ovr); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_basic;
        int b0, f0, o0;
        b0 = beat_total; f0 = ferr_total; o0 = ovr_total;
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        idle(20);
        checks++; if (beat_total - b0 !== 1) begin errors++; $display("FAIL basic_beats got=%0d want=1", beat_total - b0); end
        checks++; if (beats[b0] !== 32'h12345678) begin errors++; $display("FAIL basic_data got=%h want=12345678", beats[b0]); end
        checks++; if (ferr_total - f0 !== 0) begin errors++; $display("FAIL basic_ferr got=%0d want=0", ferr_total - f0); end
        checks++; if (ovr_total - o0 !== 0) begin errors++; $display("FAIL basic_ovr got=%0d want=0", ovr_total - o0); end
    endtask

    task automatic test_glitch;
        int b0, f0;
        b0 = beat_total; f0 = ferr_total;
        line = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(40);
        checks++; if (beat_total - b0 !== 0) begin errors++; $display("FAIL glitch_beats got=%0d want=0", beat_total - b0); end
        checks++; if (ferr_total - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got=%0d want=0", ferr_total - f0); end
        send_word(32'hCAFEBABE);
        idle(20);
        checks++; if (beat_total - b0 !== 1) begin errors++; $display("FAIL glitch_after_beats got=%0d want=1", beat_total - b0); end
        checks++; if (beats[b0] !== 32'hCAFEBABE) begin errors++; $display("FAIL glitch_after_data got=%h want=cafebabe", beats[b0]); end
    endtask

    task automatic test_frame_error;
        int b0, f0;
        b0 = beat_total; f0 = ferr_total;
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        idle(30);
        checks++; if (ferr_total - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got=%0d want=1", ferr_total - f0); end
        checks++; if (beat_total - b0 !== 0) begin errors++; $display("FAIL ferr_nobeat got=%0d want=0", beat_total - b0); end
        send_byte(8'hA1, 1'b1); send_byte(8'hA2, 1'b1);
        send_byte(8'hA3, 1'b1); send_byte(8'hA4, 1'b1);
        idle(20);
        checks++; if (beat_total - b0 !== 1) begin errors++; $display("FAIL ferr_recover_beats got=%0d want=1", beat_total - b0); end
        checks++; if (beats[b0] !== 32'hA4A3A2A1) begin errors++; $display("FAIL ferr_recover_data got=%h want=a4a3a2a1", beats[b0]); end
    endtask

    task automatic test_overrun;
        int b0, o0;
        b0 = beat_total; o0 = ovr_total;
        tready = 1'b0;
        send_word(32'h04030201);
        send_word(32'h08070605);
        idle(20);
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid got=%b want=1", tvalid); end
        checks++; if (tdata !== 32'h04030201) begin errors++; $display("FAIL ovr_held_data got=%h want=04030201", tdata); end
        checks++; if (ovr_total - o0 !== 1) begin errors++; $display("FAIL ovr_pulse got=%0d want=1", ovr_total - o0); end
        checks++; if (beat_total - b0 !== 0) begin errors++; $display("FAIL ovr_nobeat got=%0d want=0", beat_total - b0); end
        tready = 1'b1;
        idle(5);
        @(negedge clk);
        checks++; if (beat_total - b0 !== 1) begin errors++; $display("FAIL ovr_release_beats got=%0d want=1", beat_total - b0); end
        checks++; if (beats[b0] !== 32'h04030201) begin errors++; $display("FAIL ovr_release_data got=%h want=04030201", beats[b0]); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL ovr_release_clear got=%b want=0", tvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_midframe_reset;
        int b0;
        logic [7:0] d;
        d = 8'h5A;
        send_byte(8'hF0, 1'b1); send_byte(8'h0F, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        line = d[4];
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; line = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid got=%b want=0", tvalid); end
        checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL rst_mid_tdata got=%h want=00000000", tdata); end
        checks++; if (ferr !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses got=%b%b want=00", ferr, ovr); end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(30);
        b0 = beat_total;
        send_word(32'h9ABCDEF0);
        idle(20);
        checks++; if (beat_total - b0 !== 1) begin errors++; $display("FAIL rst_fresh_beats got=%0d want=1", beat_total - b0); end
        checks++; if (beats[b0] !== 32'h9ABCDEF0) begin errors++; $display("FAIL rst_fresh_data got=%h want=9abcdef0", beats[b0]); end
    endtask

    task automatic test_back_to_back;
        int b0, f0;
        logic [31:0] exp [3];
        exp[0] = 32'hDEADBEEF; exp[1] = 32'h0D15EA5E; exp[2] = 32'h01234567;
        b0 = beat_total; f0 = ferr_total;
        for (int w = 0; w < 3; w++) send_word(exp[w]);
        idle(20);
        checks++; if (beat_total - b0 !== 3) begin errors++; $display("FAIL b2b_beats got=%0d want=3", beat_total - b0); end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (beats[b0 + w] !== exp[w]) begin
                errors++; $display("FAIL b2b_data%0d got=%h want=%h", w, beats[b0 + w], exp[w]);
            end
        end
        checks++; if (ferr_total - f0 !== 0) begin errors++; $display("FAIL b2b_ferr got=%0d want=0", ferr_total - f0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_midframe_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
